// File: rtl/shift_seq_ctrl.sv
// Multi-cycle barrel-shift sequencer: computes an ARM-style register-shifted
// operand STEP bit positions per cycle, stalling the pipeline until done.
module shift_seq_ctrl #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] val_rm,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amt,
  input  logic        carry_in,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state;
  logic [31:0] data;
  logic [1:0]  typ;
  logic [5:0]  rem;
  logic        over;

  logic [5:0]  eff;
  logic [5:0]  k;
  logic [4:0]  lo_idx;
  logic [4:0]  hi_idx;
  logic [31:0] sh_val;
  logic        sh_c;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    eff = 6'd0;
    if (shift_type == ROR) begin
      if (shift_amt == 8'd0)           eff = 6'd0;
      else if (shift_amt[4:0] == 5'd0) eff = 6'd32;
      else                             eff = {1'b0, shift_amt[4:0]};
    end else begin
      eff = (shift_amt > 8'd32) ? 6'd32 : shift_amt[5:0];
    end
  end

  // One step moves min(STEP, remaining) positions; carry is the last bit out.
  always_comb begin
    k      = (rem < STEP_W) ? rem : STEP_W;
    lo_idx = 5'(k - 6'd1);
    hi_idx = 5'(6'd32 - k);
    sh_val = data;
    sh_c   = 1'b0;
    case (typ)
      LSL: begin
        sh_val = data << k;
        sh_c   = data[hi_idx];
      end
      LSR: begin
        sh_val = data >> k;
        sh_c   = data[lo_idx];
      end
      ASR: begin
        sh_val = 32'($signed(data) >>> k);
        sh_c   = data[lo_idx];
      end
      default: begin
        sh_val = (data >> k) | (data << (6'd32 - k));
        sh_c   = data[lo_idx];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data      <= 32'd0;
      typ       <= LSL;
      rem       <= 6'd0;
      over      <= 1'b0;
      val2      <= 32'd0;
      carry_out <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      rem   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data <= val_rm;
            typ  <= shift_type;
            rem  <= eff;
            // Counts beyond 32 on logical shifts clear the carry as well.
            over <= (shift_type == LSL || shift_type == LSR) && (shift_amt > 8'd32);
            if (eff == 6'd0) begin
              state     <= DONE;
              val2      <= val_rm;
              carry_out <= carry_in;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data <= sh_val;
          rem  <= rem - k;
          if (rem == k) begin
            state     <= DONE;
            val2      <= sh_val;
            carry_out <= over ? 1'b0 : sh_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = ((state == IDLE) && start && !flush) || (state == SHIFT);

endmodule
